// File: rtl/alu_ccr_seq.sv
// Sequenced ALU: the result is registered one cycle after acceptance and the
// condition codes are settled over the next two cycles (N/C/V, then Z).
module alu_ccr_seq #(
  parameter int         op_size = 4,
  parameter logic [3:0] c_mask  = 4'b1000,
  parameter logic [3:0] v_mask  = 4'b0100,
  parameter logic [3:0] n_mask  = 4'b0010,
  parameter logic [3:0] z_mask  = 4'b0001
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [op_size-1:0] A,
  input  logic [op_size-1:0] B,
  output logic               busy,
  output logic               done,
  output logic [op_size-1:0] R,
  output logic [3:0]         CCR
);

  // state    | meaning
  // IDLE     | waiting for start; R/CCR hold
  // CALC     | latched operands produce R
  // FLAG_NCV | N from R; C/V for ADD/SUB only
  // FLAG_Z   | Z from R; done pulse follows
  typedef enum logic [1:0] {IDLE, CALC, FLAG_NCV, FLAG_Z} state_t;

  localparam int msb = op_size - 1;

  state_t             state, state_nxt;
  logic [op_size-1:0] a_q, b_q, res;
  logic [1:0]         op_q;
  logic [op_size:0]   sum_ext, dif_ext;
  logic [3:0]         ccr_nxt;
  logic               accept, ld_r, ld_ncv, ld_z, ovf_add, ovf_sub;

  function automatic logic [3:0] put_flag(input logic [3:0] v, input logic [3:0] m,
                                          input logic b);
    return b ? (v | m) : (v & ~m);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = CALC;
      CALC:     state_nxt = FLAG_NCV;
      FLAG_NCV: state_nxt = FLAG_Z;
      FLAG_Z:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    accept = (state == IDLE) && start;
    ld_r   = (state == CALC);
    ld_ncv = (state == FLAG_NCV);
    ld_z   = (state == FLAG_Z);
  end

  always_comb begin
    sum_ext = {1'b0, a_q} + {1'b0, b_q};
    dif_ext = {1'b0, a_q} - {1'b0, b_q};
    case (op_q)
      2'b00:   res = a_q & b_q;
      2'b01:   res = a_q | b_q;
      2'b10:   res = sum_ext[msb:0];
      default: res = dif_ext[msb:0];
    endcase
  end

  // Overflow is judged against the registered R, which is stable by FLAG_NCV.
  always_comb begin
    ovf_add = (a_q[msb] == b_q[msb]) && (R[msb] != a_q[msb]);
    ovf_sub = (a_q[msb] != b_q[msb]) && (R[msb] != a_q[msb]);
    ccr_nxt = CCR;
    if (ld_ncv) begin
      ccr_nxt = put_flag(ccr_nxt, n_mask, R[msb]);
      if (op_q == 2'b10) begin
        ccr_nxt = put_flag(ccr_nxt, c_mask, sum_ext[op_size]);
        ccr_nxt = put_flag(ccr_nxt, v_mask, ovf_add);
      end else if (op_q == 2'b11) begin
        ccr_nxt = put_flag(ccr_nxt, c_mask, dif_ext[op_size]);
        ccr_nxt = put_flag(ccr_nxt, v_mask, ovf_sub);
      end
    end
    if (ld_z) ccr_nxt = put_flag(ccr_nxt, z_mask, (R == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      R    <= '0;
      CCR  <= '0;
      done <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= op;
      end
      if (ld_r) R <= res;
      CCR  <= ccr_nxt;
      done <= ld_z;
    end
  end

endmodule

// File: tb/tb_alu_ccr_seq.sv
// Directed bench for alu_ccr_seq: the driver queues expected R/CCR per issued
// operation and a monitor checks them whenever done is presented.
module tb_alu_ccr_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, busy, done;
  logic [1:0] op;
  logic [3:0] A, B, R, CCR;

  int         vectors = 0;
  int         miscompares = 0;
  int         done_seen = 0;
  logic [7:0] sb_q[$];

  localparam logic [1:0] OP_AND = 2'b00, OP_OR = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11;

  alu_ccr_seq #(.op_size(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .R(R), .CCR(CCR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen++;
      chk("busy_at_done", {7'd0, busy}, 8'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 8'd1, 8'd0);
      end else begin
        logic [7:0] e;
        e = sb_q.pop_front();
        chk("result_r", {4'd0, R}, {4'd0, e[7:4]});
        chk("result_ccr", {4'd0, CCR}, {4'd0, e[3:0]});
      end
    end
  end

  // Issues one operation, scrambles inputs after acceptance and checks R one
  // cycle later; returns after the edge that sets done.
  task automatic issue(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] er, input logic [3:0] ec);
    @(negedge clk);
    op = o; A = a; B = b; start = 1'b1;
    sb_q.push_back({er, ec});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; A = ~a; B = ~b; op = ~o;
    @(posedge clk);
    #1;
    chk("r_after_1", {4'd0, R}, {4'd0, er});
    chk("busy_mid", {7'd0, busy}, 8'd1);
    @(posedge clk);
    @(posedge clk);
  endtask

  logic [3:0] a_seq[12];
  int         d0;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; A = 4'd0; B = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_r", {4'd0, R}, 8'd0);
    chk("rst_ccr", {4'd0, CCR}, 8'd0);
    chk("rst_busy_done", {6'd0, busy, done}, 8'd0);
    rst_n = 1'b1;

    issue(OP_AND, 4'b1100, 4'b1010, 4'b1000, 4'b0010);
    issue(OP_ADD, 4'b0111, 4'b0001, 4'b1000, 4'b0110);
    issue(OP_ADD, 4'b1111, 4'b0001, 4'b0000, 4'b1001);
    issue(OP_AND, 4'b0001, 4'b0011, 4'b0001, 4'b1000);
    issue(OP_SUB, 4'b0000, 4'b0001, 4'b1111, 4'b1010);
    issue(OP_SUB, 4'b1000, 4'b0001, 4'b0111, 4'b0100);
    issue(OP_OR,  4'b0101, 4'b1010, 4'b1111, 4'b0110);

    // R/CCR must hold across idle cycles
    repeat (3) @(negedge clk);
    chk("hold_r", {4'd0, R}, 8'b0000_1111);
    chk("hold_ccr", {4'd0, CCR}, 8'b0000_0110);
    chk("idle_busy", {7'd0, busy}, 8'd0);

    // start held high, A changing every cycle: accepts only at slots 0, 4, 8
    a_seq = '{4'b0011, 4'b1010, 4'b0101, 4'b1100, 4'b0111, 4'b0010,
              4'b1110, 4'b1001, 4'b1111, 4'b0100, 4'b1011, 4'b0110};
    d0 = done_seen;
    sb_q.push_back({4'b0100, 4'b0000});
    sb_q.push_back({4'b1000, 4'b0110});
    sb_q.push_back({4'b0000, 4'b1001});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      op = OP_ADD; B = 4'b0001; A = a_seq[i]; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_done_count", 8'(done_seen - d0), 8'd3);

    // reset pulse in FLAG_NCV aborts the operation without a done pulse
    d0 = done_seen;
    @(negedge clk);
    op = OP_ADD; A = 4'b0011; B = 4'b0001; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_r", {4'd0, R}, 8'd0);
    chk("abort_ccr", {4'd0, CCR}, 8'd0);
    chk("abort_busy_done", {6'd0, busy, done}, 8'd0);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", 8'(done_seen - d0), 8'd0);

    issue(OP_SUB, 4'b1000, 4'b0001, 4'b0111, 4'b0100);

    for (int t = 0; t < 20 && sb_q.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 8'(sb_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
